// File: rtl/branch_seq.sv
// Four-state conditional-branch sequencer: computes the branch target, samples the
// comparator once, then issues a one-cycle PC load strobe if the branch is taken.
module branch_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] pc_in,
  input  logic [15:0] imm,
  input  logic        cond_taken,
  output logic        UC_control,
  output logic [31:0] pc_out,
  output logic        pc_write,
  output logic        busy,
  output logic        done,
  output logic        taken,
  output logic [7:0]  taken_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TARGET  = 2'd1,
    COMPARE = 2'd2,
    WRITE   = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_lat_reg;
  logic [15:0] imm_lat_reg;
  logic [31:0] pc_out_reg;
  logic        taken_reg;
  logic [7:0]  taken_cnt_reg;
  logic [31:0] offset;

  // Word offset: sign-extended immediate scaled by 4; the add wraps modulo 2^32.
  assign offset = {{14{imm_lat_reg[15]}}, imm_lat_reg, 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      pc_lat_reg    <= '0;
      imm_lat_reg   <= '0;
      pc_out_reg    <= '0;
      taken_reg     <= 1'b0;
      taken_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        pc_lat_reg  <= pc_in;
        imm_lat_reg <= imm;
      end
      if (state_reg == TARGET) begin
        pc_out_reg <= pc_lat_reg + offset;
      end
      if (state_reg == COMPARE) begin
        taken_reg <= cond_taken;
      end
      if (state_reg == WRITE && taken_reg && taken_cnt_reg != 8'hFF) begin
        taken_cnt_reg <= taken_cnt_reg + 8'd1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    UC_control = 1'b0;
    pc_write   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = TARGET;
      end
      TARGET: begin
        state_next = COMPARE;
      end
      COMPARE: begin
        UC_control = 1'b1;
        state_next = WRITE;
      end
      WRITE: begin
        done       = 1'b1;
        pc_write   = taken_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign pc_out    = pc_out_reg;
  assign taken     = taken_reg;
  assign taken_cnt = taken_cnt_reg;

endmodule
